// File: rtl/booth_pkg.sv
// Shared types and sizing for the Booth multiplier issue/collect sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents:
//   BOOTH_W_IN / BOOTH_W_PROD : default operand and product widths
//   seq_state_e               : sequencer FSM states
//   res_entry_t               : one result FIFO entry {product, error}
//   ptr_width()               : pointer width for a DEPTH-entry FIFO (min 1 bit)
package booth_pkg;

   localparam int BOOTH_W_IN   = 16;
   localparam int BOOTH_W_PROD = 2 * BOOTH_W_IN;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      WAIT = 2'd2
   } seq_state_e;

   typedef struct packed {
      logic [BOOTH_W_PROD-1:0] product;
      logic                    error;
   } res_entry_t;

   localparam int RES_ENTRY_W = $bits(res_entry_t);

   // A single-entry FIFO still needs a 1-bit pointer so the vector is legal.
   function automatic int ptr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/booth_result_fifo.sv
// Small synchronous FIFO holding completed multiplier results.
// Latency: a push is visible at the head the cycle after the push edge.
// Backpressure: none internally; the caller reserves space before pushing.
//
// Ports:
//   i_clk, i_reset       : clock, synchronous active-high reset
//   i_push, i_push_dat   : write one entry
//   i_pop                : remove the head entry (ignored when empty)
//   o_vld, o_head_dat    : head valid / head data (zero when empty)
//   o_count              : current occupancy
module booth_result_fifo
   import booth_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int WIDTH = RES_ENTRY_W,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_push_dat,
   input  logic             i_pop,
   output logic             o_vld,
   output logic [WIDTH-1:0] o_head_dat,
   output logic [CNT_W-1:0] o_count
);

   localparam int PTR_W = ptr_width(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_pop;

   // Explicit wrap keeps the pointers correct for DEPTH == 1 as well.
   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign w_pop = i_pop && (r_count != '0);

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else begin
         if (i_push) begin
            r_mem[r_wr_ptr] <= i_push_dat;
            r_wr_ptr        <= next_ptr(r_wr_ptr);
         end
         if (w_pop) begin
            r_rd_ptr <= next_ptr(r_rd_ptr);
         end
         // Simultaneous push and pop leaves the occupancy unchanged.
         case ({i_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_vld      = (r_count != '0);
   // Stale storage is hidden so the head reads zero whenever nothing is queued.
   assign o_head_dat = o_vld ? r_mem[r_rd_ptr] : '0;
   assign o_count    = r_count;

endmodule

// File: rtl/booth_mul_sequencer.sv
// Issues operand pairs to a Booth multiplier and collects its products into a result FIFO.
// Latency: accept at T, mul_ld at T+1, multiplier done at D, result valid at D+1.
// Backpressure: op_ready only in IDLE with a free FIFO slot; results held until res_ready.
//
// Ports:
//   i_clk, i_reset                  : clock, synchronous active-high reset (shared with multiplier)
//   i_op_valid/o_op_ready           : operand handshake, i_op_a multiplicand, i_op_b multiplier
//   o_mul_in_a/b, o_mul_ld(_pp)     : multiplier operands (held) and one-cycle load strobes
//   i_mul_ld_p, i_mul_product       : multiplier completion strobe and product
//   o_res_valid/i_res_ready         : result handshake, o_res_product, o_res_error (timeout)
//   o_busy                          : a job is in flight (state != IDLE)
module booth_mul_sequencer
   import booth_pkg::*;
#(
   parameter int Width_inputs   = BOOTH_W_IN,
   parameter int Width_product  = BOOTH_W_PROD,
   parameter int DEPTH          = 2,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                     i_clk,
   input  logic                     i_reset,
   input  logic                     i_op_valid,
   output logic                     o_op_ready,
   input  logic [Width_inputs-1:0]  i_op_a,
   input  logic [Width_inputs-1:0]  i_op_b,
   output logic [Width_inputs-1:0]  o_mul_in_a,
   output logic [Width_inputs-1:0]  o_mul_in_b,
   output logic                     o_mul_ld,
   output logic                     o_mul_ld_pp,
   input  logic                     i_mul_ld_p,
   input  logic [Width_product-1:0] i_mul_product,
   output logic                     o_res_valid,
   input  logic                     i_res_ready,
   output logic [Width_product-1:0] o_res_product,
   output logic                     o_res_error,
   output logic                     o_busy
);

   localparam int CNT_W  = $clog2(DEPTH + 1);
   localparam int WDOG_W = $clog2(TIMEOUT_CYCLES + 1);

   // ------------------------------------------------------------------
   // Elaboration-time parameter sanity
   // ------------------------------------------------------------------
   if (Width_product != 2 * Width_inputs) begin : g_bad_prod_width
      $error("booth_mul_sequencer: Width_product must equal 2*Width_inputs");
   end
   // The FIFO entry layout comes from the package, so widths must match it.
   if (Width_product != BOOTH_W_PROD) begin : g_bad_entry_width
      $error("booth_mul_sequencer: Width_product must match booth_pkg::BOOTH_W_PROD");
   end
   if (DEPTH < 1 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("booth_mul_sequencer: DEPTH must be a power of two >= 1");
   end
   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("booth_mul_sequencer: TIMEOUT_CYCLES must be >= 1");
   end

   // ------------------------------------------------------------------
   // State and datapath registers
   // ------------------------------------------------------------------
   seq_state_e              r_state;
   seq_state_e              w_state_nxt;
   logic [Width_inputs-1:0] r_in_a;
   logic [Width_inputs-1:0] r_in_b;
   logic [WDOG_W-1:0]       r_wdog;

   logic                    w_space;
   logic                    w_accept;
   logic                    w_push;
   res_entry_t              w_push_entry;
   res_entry_t              w_head;
   logic                    w_fifo_vld;
   logic [CNT_W-1:0]        w_fifo_count;
   logic                    w_pop;
   logic                    w_timeout;

   // Space is reserved at accept: only one job is ever in flight and the FIFO
   // can only drain while it runs, so the completion push always finds room.
   assign w_space    = (w_fifo_count < CNT_W'(DEPTH));
   assign o_op_ready = (r_state == IDLE) && w_space;
   assign w_accept   = i_op_valid && o_op_ready;
   assign w_timeout  = (r_wdog == WDOG_W'(TIMEOUT_CYCLES - 1));

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ------------------------------------------------------------------
   // FSM: next state, strobes and completion push
   // ------------------------------------------------------------------
   always_comb begin
      w_state_nxt  = r_state;
      o_mul_ld     = 1'b0;
      o_mul_ld_pp  = 1'b0;
      w_push       = 1'b0;
      w_push_entry = '0;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_state_nxt = LOAD;
            end
         end
         LOAD: begin
            o_mul_ld    = 1'b1;
            o_mul_ld_pp = 1'b1;
            w_state_nxt = WAIT;
         end
         WAIT: begin
            // A real completion on the last watchdog cycle still counts as good.
            if (i_mul_ld_p) begin
               w_push               = 1'b1;
               w_push_entry.product = i_mul_product;
               w_push_entry.error   = 1'b0;
               w_state_nxt          = IDLE;
            end else if (w_timeout) begin
               w_push               = 1'b1;
               w_push_entry.product = '0;
               w_push_entry.error   = 1'b1;
               w_state_nxt          = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Operand registers: captured on accept, held for the whole job
   // ------------------------------------------------------------------
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_in_a <= '0;
         r_in_b <= '0;
      end else if (w_accept) begin
         r_in_a <= i_op_a;
         r_in_b <= i_op_b;
      end
   end

   // ------------------------------------------------------------------
   // Watchdog: cleared while loading, counts every WAIT cycle
   // ------------------------------------------------------------------
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_wdog <= '0;
      end else if (r_state == LOAD) begin
         r_wdog <= '0;
      end else if (r_state == WAIT) begin
         r_wdog <= r_wdog + 1'b1;
      end
   end

   // ------------------------------------------------------------------
   // Result FIFO
   // ------------------------------------------------------------------
   assign w_pop = w_fifo_vld && i_res_ready;

   booth_result_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (RES_ENTRY_W),
      .CNT_W (CNT_W)
   ) u_result_fifo (
      .i_clk      (i_clk),
      .i_reset    (i_reset),
      .i_push     (w_push),
      .i_push_dat (w_push_entry),
      .i_pop      (w_pop),
      .o_vld      (w_fifo_vld),
      .o_head_dat (w_head),
      .o_count    (w_fifo_count)
   );

   assign o_mul_in_a    = r_in_a;
   assign o_mul_in_b    = r_in_b;
   assign o_res_valid   = w_fifo_vld;
   assign o_res_product = w_head.product;
   assign o_res_error   = w_head.error;
   assign o_busy        = (r_state != IDLE);

endmodule

// File: tb/tb_booth_mul_sequencer.sv
// Self-checking bench for booth_mul_sequencer with a behavioural multiplier stub.
// Latency: stub completes a programmable number of cycles after mul_ld (0 = never).
// Backpressure: res_ready driven by the directed sequences below.
module tb_booth_mul_sequencer;

   logic        clk;
   logic        reset;
   logic        op_valid;
   logic        op_ready;
   logic [15:0] op_a;
   logic [15:0] op_b;
   logic [15:0] mul_in_a;
   logic [15:0] mul_in_b;
   logic        mul_ld;
   logic        mul_ld_pp;
   logic        mul_ld_p;
   logic [31:0] mul_product;
   logic        res_valid;
   logic        res_ready;
   logic [31:0] res_product;
   logic        res_error;
   logic        busy;

   int          n_checks;
   int          n_fail;
   logic [32:0] sb_q[$];

   int          stub_lat;
   logic        stub_fixed;
   logic        stray_req;
   int          ld_cnt;

   booth_mul_sequencer #(
      .Width_inputs   (16),
      .Width_product  (32),
      .DEPTH          (2),
      .TIMEOUT_CYCLES (64)
   ) dut (
      .i_clk         (clk),
      .i_reset       (reset),
      .i_op_valid    (op_valid),
      .o_op_ready    (op_ready),
      .i_op_a        (op_a),
      .i_op_b        (op_b),
      .o_mul_in_a    (mul_in_a),
      .o_mul_in_b    (mul_in_b),
      .o_mul_ld      (mul_ld),
      .o_mul_ld_pp   (mul_ld_pp),
      .i_mul_ld_p    (mul_ld_p),
      .i_mul_product (mul_product),
      .o_res_valid   (res_valid),
      .i_res_ready   (res_ready),
      .o_res_product (res_product),
      .o_res_error   (res_error),
      .o_busy        (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, failures so far %0d", n_fail);
      $fatal(1, "global timeout");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_fail(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: bound expired or unexpected event", name);
   endtask

   // ------------------------------------------------------------------
   // Multiplier stub: drives its outputs on the falling edge
   // ------------------------------------------------------------------
   initial begin
      int                 cnt;
      logic [15:0]        sa;
      logic [15:0]        sbv;
      logic signed [31:0] prod;
      cnt         = 0;
      sa          = '0;
      sbv         = '0;
      mul_ld_p    = 1'b0;
      mul_product = '0;
      forever begin
         @(negedge clk);
         mul_ld_p = 1'b0;
         if (reset) begin
            cnt = 0;
         end else if (stray_req) begin
            mul_ld_p    = 1'b1;
            mul_product = 32'hDEADBEEF;
            stray_req   = 1'b0;
         end else if (mul_ld) begin
            cnt = stub_lat;
            sa  = mul_in_a;
            sbv = mul_in_b;
            ld_cnt++;
         end else if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
               mul_ld_p = 1'b1;
               if (stub_fixed) begin
                  mul_product = 32'h00001234;
               end else begin
                  prod        = 32'($signed(sa)) * 32'($signed(sbv));
                  mul_product = prod;
               end
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Monitor: pops the scoreboard on every result handshake
   // ------------------------------------------------------------------
   initial begin
      logic [32:0] exp;
      logic        prev_done;
      prev_done = 1'b0;
      forever begin
         @(negedge clk);
         #2;
         if (reset) begin
            prev_done = 1'b0;
         end else begin
            if (prev_done) begin
               chk("done_to_valid", 64'(res_valid), 64'(1));
            end
            prev_done = mul_ld_p && busy;
            if (res_valid && res_ready) begin
               if (sb_q.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL unexpected_result: got product %0h error %0b, expected nothing",
                           res_product, res_error);
               end else begin
                  exp = sb_q.pop_front();
                  chk("result", 64'({res_product, res_error}), 64'(exp));
               end
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Stimulus helpers (called at posedge + 1)
   // ------------------------------------------------------------------
   task automatic issue(input logic [15:0] a, input logic [15:0] b,
                        input logic [31:0] p, input logic e);
      int i;
      op_a     = a;
      op_b     = b;
      op_valid = 1'b1;
      sb_q.push_back({p, e});
      i = 0;
      while (!op_ready && i < 300) begin
         @(posedge clk);
         #1;
         i++;
      end
      if (!op_ready) begin
         chk_fail("accept_timeout");
      end else begin
         @(posedge clk);
         #1;
      end
      op_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int i;
      i = 0;
      while (busy && i < 300) begin
         @(posedge clk);
         #1;
         i++;
      end
      if (busy) chk_fail("idle_timeout");
   endtask

   task automatic drain();
      int i;
      i = 0;
      while (sb_q.size() != 0 && i < 300) begin
         @(posedge clk);
         #1;
         i++;
      end
      if (sb_q.size() != 0) chk_fail("drain_timeout");
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_mul_in_a"},    64'(mul_in_a),    64'(0));
      chk({tag, "_mul_in_b"},    64'(mul_in_b),    64'(0));
      chk({tag, "_mul_ld"},      64'(mul_ld),      64'(0));
      chk({tag, "_mul_ld_pp"},   64'(mul_ld_pp),   64'(0));
      chk({tag, "_res_valid"},   64'(res_valid),   64'(0));
      chk({tag, "_res_product"}, 64'(res_product), 64'(0));
      chk({tag, "_res_error"},   64'(res_error),   64'(0));
      chk({tag, "_busy"},        64'(busy),        64'(0));
   endtask

   // ------------------------------------------------------------------
   // Directed sequences
   // ------------------------------------------------------------------
   initial begin
      int k;
      int ld0;
      n_checks   = 0;
      n_fail     = 0;
      reset      = 1'b1;
      op_valid   = 1'b0;
      op_a       = '0;
      op_b       = '0;
      res_ready  = 1'b0;
      stub_lat   = 17;
      stub_fixed = 1'b0;
      stray_req  = 1'b0;
      ld_cnt     = 0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      reset = 1'b0;
      @(posedge clk);
      #1;
      chk("reset_op_ready", 64'(op_ready), 64'(1));

      // 1: 3 * -5 = -15, one load pulse, valid one cycle after ld_p
      res_ready = 1'b1;
      ld0 = ld_cnt;
      issue(16'd3, 16'hFFFB, 32'hFFFFFFF1, 1'b0);
      chk("t1_mul_ld",    64'(mul_ld),    64'(1));
      chk("t1_mul_ld_pp", 64'(mul_ld_pp), 64'(1));
      chk("t1_mul_in_a",  64'(mul_in_a),  64'(16'd3));
      chk("t1_mul_in_b",  64'(mul_in_b),  64'(16'hFFFB));
      chk("t1_op_ready",  64'(op_ready),  64'(0));
      @(posedge clk);
      #1;
      chk("t1_ld_drop",    64'(mul_ld),    64'(0));
      chk("t1_ld_pp_drop", 64'(mul_ld_pp), 64'(0));
      chk("t1_busy",       64'(busy),      64'(1));
      k = 1;
      while (!res_valid && k < 100) begin
         @(posedge clk);
         #1;
         k++;
      end
      chk("t1_latency", 64'(k), 64'(18));
      wait_idle();
      drain();
      chk("t1_ld_pulses", 64'(ld_cnt - ld0), 64'(1));

      // 2: FIFO fills under backpressure, third job waits, order kept
      res_ready = 1'b0;
      stub_lat  = 5;
      issue(16'd7, 16'd6, 32'd42, 1'b0);
      wait_idle();
      issue(16'd100, 16'd200, 32'd20000, 1'b0);
      wait_idle();
      @(posedge clk);
      #1;
      chk("t2_full_op_ready", 64'(op_ready),    64'(0));
      chk("t2_head",          64'(res_product), 64'(42));
      op_a     = 16'd12;
      op_b     = 16'd12;
      op_valid = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      chk("t2_blocked_busy", 64'(busy),        64'(0));
      chk("t2_head_stable",  64'(res_product), 64'(42));
      res_ready = 1'b1;
      issue(16'd12, 16'd12, 32'd144, 1'b0);
      wait_idle();
      drain();

      // 3: multiplier never completes -> error result after 64 WAIT cycles
      stub_lat = 0;
      issue(16'd1, 16'd1, 32'd0, 1'b1);
      k = 0;
      while (!res_valid && k < 100) begin
         @(posedge clk);
         #1;
         k++;
      end
      chk("t3_timeout_latency", 64'(k),         64'(65));
      chk("t3_error",           64'(res_error), 64'(1));
      chk("t3_busy",            64'(busy),      64'(0));
      drain();
      stub_lat = 5;
      issue(16'hFFFE, 16'd9, 32'hFFFFFFEE, 1'b0);
      wait_idle();
      drain();

      // 4: completion on the timeout cycle wins
      stub_lat   = 64;
      stub_fixed = 1'b1;
      issue(16'd5, 16'd5, 32'h00001234, 1'b0);
      wait_idle();
      drain();
      repeat (3) @(posedge clk);
      #1;
      chk("t4_single_push", 64'(res_valid), 64'(0));
      stub_fixed = 1'b0;

      // 5: reset during WAIT with one entry queued
      res_ready = 1'b0;
      stub_lat  = 5;
      issue(16'd2, 16'd3, 32'd6, 1'b0);
      wait_idle();
      stub_lat = 30;
      issue(16'd4, 16'd4, 32'd16, 1'b0);
      repeat (5) @(posedge clk);
      #1;
      chk("t5_in_wait", 64'(busy), 64'(1));
      reset = 1'b1;
      sb_q.delete();
      @(posedge clk);
      #1;
      check_reset_outputs("t5");
      reset     = 1'b0;
      res_ready = 1'b1;
      stub_lat  = 17;
      issue(16'h8000, 16'h8000, 32'h40000000, 1'b0);
      wait_idle();
      drain();

      // 6: pop and push in the same cycle, then a stray ld_p while idle
      res_ready = 1'b0;
      stub_lat  = 6;
      issue(16'd1, 16'd2, 32'd2, 1'b0);
      wait_idle();
      issue(16'd3, 16'd4, 32'd12, 1'b0);
      repeat (6) @(posedge clk);
      #1;
      res_ready = 1'b1;
      @(posedge clk);
      #1;
      res_ready = 1'b0;
      chk("t6_valid_after_swap", 64'(res_valid),   64'(1));
      chk("t6_head_after_swap",  64'(res_product), 64'(12));
      chk("t6_idle",             64'(busy),        64'(0));
      stray_req = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      res_ready = 1'b1;
      drain();
      repeat (3) @(posedge clk);
      #1;
      chk("t6_no_stray_push", 64'(res_valid),   64'(0));
      chk("final_sb_empty",   64'(sb_q.size()), 64'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
